// File: rtl/tenthirty_ctrl.sv
// Game-flow controller for ten-and-a-half; all scores are kept in half-point units.
// Optional five-card-win rule is enabled by defining TENTHIRTY_FIVE_CARD_EN.
module tenthirty_ctrl #(
    parameter int unsigned ROUNDS       = 4,
    parameter int unsigned DEALER_STAND = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_m,
    input  logic       btn_r,
    output logic       card_req,
    input  logic       card_vld,
    input  logic [3:0] card_val,
    output logic [5:0] p_score,
    output logic [5:0] d_score,
    output logic [2:0] p_cards,
    output logic [2:0] d_cards,
    output logic [3:0] round_no,
    output logic [2:0] led,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StPDraw  = 4'd1,
        StPChk   = 4'd2,
        StPWait  = 4'd3,
        StDDraw  = 4'd4,
        StDChk   = 4'd5,
        StResult = 4'd6,
        StShow   = 4'd7,
        StOver   = 4'd8
    } state_e;

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);
    localparam logic [5:0] STAND      = 6'(DEALER_STAND);
    localparam logic [5:0] MAX_SCORE  = 6'd21;

    state_e     state_q, state_d;
    logic       btn_m_q, btn_r_q;
    logic       card_req_q;
    logic [5:0] p_score_q, p_score_d, d_score_q, d_score_d;
    logic [2:0] p_cards_q, p_cards_d, d_cards_q, d_cards_d;
    logic [3:0] round_q, round_d;
    logic [2:0] led_q, led_d;
    logic       press_m, press_r, accept;
    logic [5:0] card_pts;
    logic [2:0] result_led;

    assign press_m  = tick && btn_m && !btn_m_q;
    assign press_r  = tick && btn_r && !btn_r_q;
    assign accept   = tick && card_req_q && card_vld;
    assign card_pts = (card_val <= 4'd10) ? {1'b0, card_val, 1'b0} : 6'd1;

    // A five-card win needs no special case: the dealer holds 0, so p > d already yields 001.
    always_comb begin
        if (p_score_q > MAX_SCORE)      result_led = 3'b010;
        else if (d_score_q > MAX_SCORE) result_led = 3'b001;
        else if (p_score_q > d_score_q) result_led = 3'b001;
        else if (p_score_q < d_score_q) result_led = 3'b010;
        else                            result_led = 3'b100;
    end

    // All state advances only on divider ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            btn_m_q    <= 1'b0;
            btn_r_q    <= 1'b0;
            card_req_q <= 1'b0;
            p_score_q  <= '0;
            d_score_q  <= '0;
            p_cards_q  <= '0;
            d_cards_q  <= '0;
            round_q    <= '0;
            led_q      <= '0;
        end else if (tick) begin
            state_q    <= state_d;
            btn_m_q    <= btn_m;
            btn_r_q    <= btn_r;
            card_req_q <= (state_d == StPDraw) || (state_d == StDDraw);
            p_score_q  <= p_score_d;
            d_score_q  <= d_score_d;
            p_cards_q  <= p_cards_d;
            d_cards_q  <= d_cards_d;
            round_q    <= round_d;
            led_q      <= led_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (press_m) state_d = StPDraw;
            StPDraw:  if (accept) state_d = StPChk;
            StPChk: begin
                if (p_score_q > MAX_SCORE)       state_d = StResult;
`ifdef TENTHIRTY_FIVE_CARD_EN
                else if (p_cards_q == 3'd5)      state_d = StResult;
`endif
                else if (p_score_q == MAX_SCORE) state_d = StDDraw;
                else                             state_d = StPWait;
            end
            StPWait: begin
                if (press_r)      state_d = StDDraw;
                else if (press_m) state_d = StPDraw;
            end
            StDDraw:  if (accept) state_d = StDChk;
            StDChk: begin
                if (d_score_q > MAX_SCORE || d_score_q >= STAND) state_d = StResult;
                else                                             state_d = StDDraw;
            end
            StResult: state_d = StShow;
            StShow:   if (press_m) state_d = (round_q == LAST_ROUND) ? StOver : StPDraw;
            StOver:   if (press_m) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        p_score_d = p_score_q;
        d_score_d = d_score_q;
        p_cards_d = p_cards_q;
        d_cards_d = d_cards_q;
        round_d   = round_q;
        led_d     = led_q;
        unique case (state_q)
            StPDraw: if (accept) begin
                p_score_d = p_score_q + card_pts;
                p_cards_d = (p_cards_q == 3'd7) ? 3'd7 : p_cards_q + 3'd1;
            end
            StDDraw: if (accept) begin
                d_score_d = d_score_q + card_pts;
                d_cards_d = (d_cards_q == 3'd7) ? 3'd7 : d_cards_q + 3'd1;
            end
            StResult: led_d = result_led;
            StShow: if (press_m && round_q != LAST_ROUND) begin
                round_d   = round_q + 4'd1;
                p_score_d = '0;
                d_score_d = '0;
                p_cards_d = '0;
                d_cards_d = '0;
                led_d     = '0;
            end
            StOver: if (press_m) begin
                round_d   = '0;
                p_score_d = '0;
                d_score_d = '0;
                p_cards_d = '0;
                d_cards_d = '0;
                led_d     = '0;
            end
            default: ;
        endcase
    end

    assign card_req = card_req_q;
    assign p_score  = p_score_q;
    assign d_score  = d_score_q;
    assign p_cards  = p_cards_q;
    assign d_cards  = d_cards_q;
    assign round_no = round_q;
    assign led      = led_q;
    assign state    = state_q;

endmodule
